// File: rtl/shapool_pkg.sv
// shapool_pkg: shared FSM state encoding and result width for the shapool result path.
package shapool_pkg;

    localparam int RESULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        FOUND     = 2'd2,
        EXHAUSTED = 2'd3
    } state_e;

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: clearable, enabled 32-bit counter that saturates at all-ones,
// with a terminal-count flag raised when the count equals TERMINAL.
module cycle_timer #(
    parameter logic [31:0] TERMINAL = 32'hFFFF_FFFE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        en_i,
    output logic [31:0] count_o,
    output logic        tc_o
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (en_i && count_q != '1)
            count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
    assign tc_o    = count_q == TERMINAL;

endmodule

// File: rtl/result_capture.sv
// result_capture: job FSM that captures the first shapool winner/nonce, tracks the nonce
// budget and drives host handshake and status LED. Define STATUS_BLINK_EN for a blinking LED in RUN.
module result_capture
    import shapool_pkg::*;
#(
    parameter int          POOL_SIZE_LOG2 = 1,
    parameter int          NONCE_WIDTH    = 31,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF,
    parameter int          BLINK_LOG2     = 22
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         job_start_in,
    input  logic                         success_in,
    input  logic [NONCE_WIDTH-1:0]       nonce_in,
    input  logic [POOL_SIZE_LOG2-1:0]    winner_in,
    input  logic                         ack_in,
    output logic [RESULT_DATA_WIDTH-1:0] result_out,
    output logic                         result_valid_out,
    output logic                         ready_oe_out,
    output logic                         pool_halt_out,
    output logic                         timeout_out,
    output logic                         status_led_n_out
);

    state_e                       state_q, state_d;
    logic [RESULT_DATA_WIDTH-1:0] result_q, result_d;
    logic                         valid_q, valid_d;
    logic                         ready_q;
    logic                         timeout_q, timeout_d;
    logic [31:0]                  count;
    logic                         timer_tc;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        if (job_start_in) begin
            state_d   = RUN;
            result_d  = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    // success outranks a simultaneous budget expiry
                    if (success_in) begin
                        state_d  = FOUND;
                        result_d = {winner_in, nonce_in};
                        valid_d  = 1'b1;
                    end else if (timer_tc) begin
                        state_d   = EXHAUSTED;
                        timeout_d = 1'b1;
                    end
                end
                FOUND, EXHAUSTED: begin
                    if (ack_in) begin
                        state_d   = IDLE;
                        result_d  = '0;
                        valid_d   = 1'b0;
                        timeout_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            ready_q   <= state_d == FOUND;
            timeout_q <= timeout_d;
        end
    end

    // counting stops on the edge that leaves RUN, so it never wraps
    cycle_timer #(
        .TERMINAL(TIMEOUT_CYCLES - 32'd1)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (job_start_in),
        .en_i    (state_q == RUN && state_d == RUN),
        .count_o (count),
        .tc_o    (timer_tc)
    );

    assign result_out       = result_q;
    assign result_valid_out = valid_q;
    assign ready_oe_out     = ready_q;
    assign timeout_out      = timeout_q;
    assign pool_halt_out    = state_q != RUN;

`ifdef STATUS_BLINK_EN
    logic [BLINK_LOG2-1:0] blink_q, blink_d;
    logic                  blink_led_q, blink_led_d;

    always_comb begin
        blink_d     = '0;
        blink_led_d = 1'b1;
        if (state_q == RUN) begin
            blink_d     = blink_q + 1'b1;
            blink_led_d = &blink_q ? ~blink_led_q : blink_led_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q     <= '0;
            blink_led_q <= 1'b1;
        end else begin
            blink_q     <= blink_d;
            blink_led_q <= blink_led_d;
        end
    end

    assign status_led_n_out = state_q == FOUND ? 1'b0 : state_q == RUN ? blink_led_q : 1'b1;
`else
    logic unused_blink;
    assign unused_blink     = ^BLINK_LOG2;
    assign status_led_n_out = state_q != FOUND;
`endif

    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_result_capture.sv
// tb_result_capture: directed and randomized checks of result_capture against a
// cycle-level behavioural model of the job lifecycle.
module tb_result_capture;
    import shapool_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        job_start_in = 1'b0, success_in = 1'b0, ack_in = 1'b0;
    logic [30:0] nonce_in = '0;
    logic [0:0]  winner_in = '0;
    logic [31:0] result_out;
    logic        result_valid_out, ready_oe_out, pool_halt_out, timeout_out, status_led_n_out;

    int checks = 0, errors = 0;

    // model: phase 0 idle, 1 running, 2 found, 3 exhausted; runs = RUN cycles spent
    int          m_ph = 0;
    int          m_runs = 0;
    logic [31:0] m_res = '0;

    result_capture #(
        .POOL_SIZE_LOG2 (1),
        .NONCE_WIDTH    (31),
        .TIMEOUT_CYCLES (32'd16),
        .BLINK_LOG2     (3)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .job_start_in     (job_start_in),
        .success_in       (success_in),
        .nonce_in         (nonce_in),
        .winner_in        (winner_in),
        .ack_in           (ack_in),
        .result_out       (result_out),
        .result_valid_out (result_valid_out),
        .ready_oe_out     (ready_oe_out),
        .pool_halt_out    (pool_halt_out),
        .timeout_out      (timeout_out),
        .status_led_n_out (status_led_n_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic step(input logic js, input logic succ, input logic [30:0] n, input logic w, input logic ack);
        job_start_in = js; success_in = succ; nonce_in = n; winner_in = w; ack_in = ack;
        @(posedge clk);
        if (js) begin
            m_ph = 1; m_runs = 0; m_res = '0;
        end else if (m_ph == 1) begin
            if (succ) begin
                m_ph = 2; m_res = {w, n};
            end else if (m_runs + 1 == TO) begin
                m_ph = 3;
            end else begin
                m_runs++;
            end
        end else if (m_ph >= 2 && ack) begin
            m_ph = 0; m_res = '0;
        end
        #1;
        job_start_in = 1'b0; success_in = 1'b0; ack_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (result_out !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result_out); end
        checks++; if (result_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", result_valid_out); end
        checks++; if (ready_oe_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_oe_out); end
        checks++; if (timeout_out !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout_out); end
        checks++; if (pool_halt_out !== 1'b1) begin errors++; $display("FAIL reset_halt got %b exp 1", pool_halt_out); end
        checks++; if (status_led_n_out !== 1'b1) begin errors++; $display("FAIL reset_led got %b exp 1", status_led_n_out); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_ph = 0; m_runs = 0; m_res = '0;
        step(1'b0, 1'b1, 31'h7, 1'b1, 1'b1);
        checks++; if (pool_halt_out !== 1'b1 || result_valid_out !== 1'b0) begin errors++; $display("FAIL idle_ignores got halt=%b valid=%b exp halt=1 valid=0", pool_halt_out, result_valid_out); end
    endtask

    task automatic test_found;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(9);
        checks++; if (pool_halt_out !== 1'b0 || result_valid_out !== 1'b0) begin errors++; $display("FAIL run_pre got halt=%b valid=%b exp halt=0 valid=0", pool_halt_out, result_valid_out); end
        step(1'b0, 1'b1, 31'h1234_5678, 1'b1, 1'b0);
        checks++; if (result_out !== 32'h9234_5678) begin errors++; $display("FAIL found_result got %h exp 92345678", result_out); end
        checks++; if (result_valid_out !== 1'b1) begin errors++; $display("FAIL found_valid got %b exp 1", result_valid_out); end
        checks++; if (ready_oe_out !== 1'b1) begin errors++; $display("FAIL found_ready got %b exp 1", ready_oe_out); end
        checks++; if (pool_halt_out !== 1'b1) begin errors++; $display("FAIL found_halt got %b exp 1", pool_halt_out); end
        checks++; if (status_led_n_out !== 1'b0) begin errors++; $display("FAIL found_led got %b exp 0", status_led_n_out); end
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++; if (result_out !== 32'h0 || result_valid_out !== 1'b0 || ready_oe_out !== 1'b0) begin errors++; $display("FAIL found_ack got res=%h valid=%b ready=%b exp 0/0/0", result_out, result_valid_out, ready_oe_out); end
    endtask

    task automatic test_timeout;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(TO - 1);
        checks++; if (timeout_out !== 1'b0 || pool_halt_out !== 1'b0) begin errors++; $display("FAIL timeout_early got to=%b halt=%b exp 0/0", timeout_out, pool_halt_out); end
        idle(1);
        checks++; if (timeout_out !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1", timeout_out); end
        checks++; if (ready_oe_out !== 1'b0 || result_valid_out !== 1'b0) begin errors++; $display("FAIL timeout_noresult got ready=%b valid=%b exp 0/0", ready_oe_out, result_valid_out); end
        checks++; if (pool_halt_out !== 1'b1 || status_led_n_out !== 1'b1) begin errors++; $display("FAIL timeout_halt_led got halt=%b led=%b exp 1/1", pool_halt_out, status_led_n_out); end
        idle(3);
        checks++; if (timeout_out !== 1'b1) begin errors++; $display("FAIL timeout_hold got %b exp 1", timeout_out); end
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++; if (timeout_out !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL timeout_ack got to=%b state=%0d exp to=0 state=IDLE", timeout_out, dut.state_q); end
    endtask

    task automatic test_success_on_timeout;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(TO - 1);
        step(1'b0, 1'b1, 31'h0ABC_DEF0, 1'b0, 1'b0);
        checks++; if (dut.state_q !== FOUND) begin errors++; $display("FAIL tie_state got %0d exp FOUND", dut.state_q); end
        checks++; if (timeout_out !== 1'b0) begin errors++; $display("FAIL tie_timeout got %b exp 0", timeout_out); end
        checks++; if (result_out !== 32'h0ABC_DEF0) begin errors++; $display("FAIL tie_result got %h exp 0abcdef0", result_out); end
    endtask

    task automatic test_hold;
        step(1'b0, 1'b1, 31'h0000_0001, 1'b1, 1'b0);
        checks++; if (result_out !== 32'h0ABC_DEF0) begin errors++; $display("FAIL hold_result got %h exp 0abcdef0", result_out); end
        checks++; if (ready_oe_out !== 1'b1 || result_valid_out !== 1'b1) begin errors++; $display("FAIL hold_flags got ready=%b valid=%b exp 1/1", ready_oe_out, result_valid_out); end
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL hold_ack_state got %0d exp IDLE", dut.state_q); end
        checks++; if (result_out !== 32'h0 || result_valid_out !== 1'b0 || ready_oe_out !== 1'b0 || timeout_out !== 1'b0) begin errors++; $display("FAIL hold_ack_clear got res=%h valid=%b ready=%b to=%b exp all 0", result_out, result_valid_out, ready_oe_out, timeout_out); end
        checks++; if (pool_halt_out !== 1'b1 || status_led_n_out !== 1'b1) begin errors++; $display("FAIL hold_ack_halt got halt=%b led=%b exp 1/1", pool_halt_out, status_led_n_out); end
    endtask

    task automatic test_start_ack;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 31'h55, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL startack_state got %0d exp RUN", dut.state_q); end
        checks++; if (dut.u_timer.count_q !== 32'd0) begin errors++; $display("FAIL startack_count got %0d exp 0", dut.u_timer.count_q); end
        checks++; if (result_valid_out !== 1'b0 || result_out !== 32'h0 || pool_halt_out !== 1'b0) begin errors++; $display("FAIL startack_out got valid=%b res=%h halt=%b exp 0/0/0", result_valid_out, result_out, pool_halt_out); end
        idle(2);
        checks++; if (dut.u_timer.count_q !== 32'd2) begin errors++; $display("FAIL startack_count2 got %0d exp 2", dut.u_timer.count_q); end
    endtask

    task automatic test_async_reset;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(3);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dut.state_q !== IDLE || dut.u_timer.count_q !== 32'd0) begin errors++; $display("FAIL areset_state got state=%0d cnt=%0d exp IDLE/0", dut.state_q, dut.u_timer.count_q); end
        checks++; if (result_out !== 32'h0 || result_valid_out !== 1'b0 || ready_oe_out !== 1'b0 || timeout_out !== 1'b0) begin errors++; $display("FAIL areset_out got res=%h valid=%b ready=%b to=%b exp all 0", result_out, result_valid_out, ready_oe_out, timeout_out); end
        checks++; if (pool_halt_out !== 1'b1 || status_led_n_out !== 1'b1) begin errors++; $display("FAIL areset_halt got halt=%b led=%b exp 1/1", pool_halt_out, status_led_n_out); end
        @(negedge clk);
        reset_n = 1'b1;
        m_ph = 0; m_runs = 0; m_res = '0;
        step(1'b0, 1'b1, 31'h3C3C, 1'b1, 1'b0);
        step(1'b0, 1'b1, 31'h4D4D, 1'b0, 1'b0);
        checks++; if (result_valid_out !== 1'b0 || pool_halt_out !== 1'b1 || dut.state_q !== IDLE) begin errors++; $display("FAIL areset_ignore got valid=%b halt=%b state=%0d exp 0/1/IDLE", result_valid_out, pool_halt_out, dut.state_q); end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 31'h0000_0042, 1'b0, 1'b0);
        checks++; if (result_out !== 32'h0000_0042 || result_valid_out !== 1'b1) begin errors++; $display("FAIL areset_rerun got res=%h valid=%b exp 00000042/1", result_out, result_valid_out); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0, 31'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            checks++; if (result_out !== m_res) begin errors++; $display("FAIL rnd_result cyc %0d got %h exp %h", i, result_out, m_res); end
            checks++; if (result_valid_out !== (m_ph == 2)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, result_valid_out, m_ph == 2); end
            checks++; if (ready_oe_out !== (m_ph == 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, ready_oe_out, m_ph == 2); end
            checks++; if (timeout_out !== (m_ph == 3)) begin errors++; $display("FAIL rnd_timeout cyc %0d got %b exp %b", i, timeout_out, m_ph == 3); end
            checks++; if (pool_halt_out !== (m_ph != 1)) begin errors++; $display("FAIL rnd_halt cyc %0d got %b exp %b", i, pool_halt_out, m_ph != 1); end
`ifdef STATUS_BLINK_EN
            if (m_ph != 1) begin
                checks++; if (status_led_n_out !== (m_ph != 2)) begin errors++; $display("FAIL rnd_led cyc %0d got %b exp %b", i, status_led_n_out, m_ph != 2); end
            end
`else
            checks++; if (status_led_n_out !== (m_ph != 2)) begin errors++; $display("FAIL rnd_led cyc %0d got %b exp %b", i, status_led_n_out, m_ph != 2); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_found();
        test_timeout();
        test_success_on_timeout();
        test_hold();
        test_start_ack();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_capture.md
RESULT_CAPTURE -- requirements
Module: result_capture

Interface
REQ-001 The block SHALL have parameter POOL_SIZE_LOG2, default 1, meaning the width of the winning-unit index.
REQ-002 The block SHALL have parameter NONCE_WIDTH, default 31, meaning the per-unit nonce width; NONCE_WIDTH + POOL_SIZE_LOG2 SHALL equal 32.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 32'hFFFF_FFFF, meaning the RUN-state cycle budget before EXHAUSTED.
REQ-004 The block SHALL have parameter BLINK_LOG2, default 22, meaning the LED half-period is 2^BLINK_LOG2 cycles.
REQ-005 The block SHALL have port clk, input, 1, the single clock; the block SHALL use one clock, and reset is asynchronous and active-low.
REQ-006 The block SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port job_start_in, input, 1, a one-cycle pulse marking a new job config as loaded.
REQ-008 The block SHALL have port success_in, input, 1, the shapool success flag.
REQ-009 The block SHALL have port nonce_in, input, NONCE_WIDTH, the shapool nonce, valid when success_in=1.
REQ-010 The block SHALL have port winner_in, input, POOL_SIZE_LOG2, the index of the successful unit, valid when success_in=1.
REQ-011 The block SHALL have port ack_in, input, 1, a one-cycle pulse marking that the host has read the result.
REQ-012 The block SHALL have port result_out, output, 32, carrying {winner, nonce} to external_io.
REQ-013 The block SHALL have port result_valid_out, output, 1, meaning result_out holds a captured result.
REQ-014 The block SHALL have port ready_oe_out, output, 1, the enable for the ready_n_ts_out open-drain pull-low.
REQ-015 The block SHALL have port pool_halt_out, output, 1; when it is 1, shapool is held idle.
REQ-016 The block SHALL have port timeout_out, output, 1, meaning the nonce budget is exhausted without success.
REQ-017 The block SHALL have port status_led_n_out, output, 1, the active-low status LED.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, RUN, FOUND, EXHAUSTED.
REQ-019 The FSM SHALL move from IDLE to RUN when job_start_in=1; all other inputs SHALL be ignored in IDLE.
REQ-020 On the RUN-to-FOUND transition (RUN with success_in=1), the FSM SHALL capture {winner_in, nonce_in} into result_out on the same edge.
REQ-021 In RUN with success_in=0 and cycle counter = TIMEOUT_CYCLES-1, the FSM SHALL move to EXHAUSTED.
REQ-022 When success_in=1 and the timeout occur in the same cycle, success SHALL win and the FSM SHALL move to FOUND.
REQ-023 In FOUND or EXHAUSTED, ack_in=1 SHALL move the FSM to IDLE and clear result_out, result_valid_out and timeout_out.
REQ-024 job_start_in=1 in any state SHALL restart RUN: counter=0, result_out=0, result_valid_out=0, timeout_out=0.
REQ-025 When job_start_in=1 and ack_in=1 occur in the same cycle, job_start_in SHALL win.
REQ-026 In FOUND, further success_in pulses SHALL be ignored, and the first result SHALL be held.
REQ-027 Latency: success_in sampled at edge N SHALL make result_valid_out=1 and ready_oe_out=1 visible after edge N+1.
REQ-028 ready_oe_out SHALL be registered and SHALL equal 1 only in FOUND.
REQ-029 pool_halt_out SHALL be decoded from state: 0 in RUN, 1 otherwise.
REQ-030 The cycle counter SHALL be 32 bits, SHALL increment only in RUN, and SHALL never wrap; it SHALL saturate at the EXHAUSTED transition.
REQ-031 result_out SHALL equal {winner_in, nonce_in}, with winner in the MSBs.

Reset
REQ-032 Asserting reset_n=0 SHALL immediately set: state=IDLE, counter=0, result_out=0, result_valid_out=0, ready_oe_out=0, timeout_out=0, pool_halt_out=1, status_led_n_out=1, blink counter=0.
REQ-033 Reset asserted mid-RUN or mid-FOUND SHALL discard any result; after reset release, a new job_start_in is required before RUN.

Configuration
REQ-034 With macro STATUS_BLINK_EN defined, status_led_n_out SHALL toggle every 2^BLINK_LOG2 cycles in RUN, be 0 in FOUND, and be 1 in IDLE and EXHAUSTED.
REQ-035 Without STATUS_BLINK_EN, no blink counter SHALL be synthesised, and status_led_n_out SHALL be 0 only in FOUND and 1 otherwise.

Structure
REQ-036 The shared package shapool_pkg SHALL hold the FSM state encoding and RESULT_DATA_WIDTH=32.
REQ-037 The block SHALL contain exactly one sub-module, cycle_timer, implementing the clear/enable/saturating 32-bit counter with a terminal-count flag.

Verification
REQ-038 The bench SHALL apply reset, then job_start_in, then at cycle 10 success_in=1 with winner_in=1 and nonce_in=31'h1234_5678; it SHALL require result_out=32'h9234_5678, result_valid_out=1 and ready_oe_out=1 at the next cycle, with pool_halt_out=1.
REQ-039 The bench SHALL set TIMEOUT_CYCLES=16, apply job_start_in and no success; it SHALL require timeout_out=1 after 16 RUN cycles, ready_oe_out=0 and result_valid_out=0.
REQ-040 The bench SHALL apply success_in=1 exactly on the timeout cycle; it SHALL require state FOUND and timeout_out=0.
REQ-041 The bench SHALL apply a second success_in in FOUND with nonce_in=31'h0000_0001; it SHALL require result_out to keep the first value, and that ack_in then returns the FSM to IDLE with outputs cleared.
REQ-042 The bench SHALL apply job_start_in and ack_in in the same cycle in FOUND; it SHALL require RUN with counter=0 and result_valid_out=0.
REQ-043 The bench SHALL assert reset_n=0 asynchronously mid-RUN; it SHALL require all outputs to reach reset values before the next clk edge, and that success_in after release is ignored until job_start_in.
